// File: rtl/data_mem_unit_pkg.sv
// Shared encodings for the data memory unit: access sizes, FSM states,
// default latency and the misaligned/illegal access check.
package data_mem_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int unsigned LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic access_error(input logic [1:0] size,
                                          input logic [1:0] offset,
                                          input logic       rd,
                                          input logic       wr);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = offset[0];
            SZ_WORD: err = (offset != 2'b00);
            default: err = 1'b1;
        endcase
        return err | (rd & wr);
    endfunction

endpackage

// File: rtl/data_mem_align.sv
// Big-endian lane steering: merges store data into the old word and
// selects/extends the addressed lane of a word for loads.
module data_mem_align
    import data_mem_unit_pkg::*;
(
    input  logic [31:0] mem_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    output logic [31:0] store_word_o,
    output logic [31:0] load_word_o
);

    logic [7:0]  lane8_s;
    logic [15:0] lane16_s;

    // Lane pick and store merge; offset 0 is the most significant lane.
    always_comb begin
        store_word_o = mem_word_i;
        load_word_o  = 32'h0000_0000;
        lane8_s      = 8'h00;
        lane16_s     = 16'h0000;

        case (offset_i)
            2'd0:    lane8_s = mem_word_i[31:24];
            2'd1:    lane8_s = mem_word_i[23:16];
            2'd2:    lane8_s = mem_word_i[15:8];
            2'd3:    lane8_s = mem_word_i[7:0];
            default: lane8_s = 8'h00;
        endcase

        if (offset_i[1]) begin
            lane16_s = mem_word_i[15:0];
        end else begin
            lane16_s = mem_word_i[31:16];
        end

        case (size_i)
            SZ_BYTE: begin
                load_word_o = {{24{sign_ext_i & lane8_s[7]}}, lane8_s};
                case (offset_i)
                    2'd0:    store_word_o[31:24] = wdata_i[7:0];
                    2'd1:    store_word_o[23:16] = wdata_i[7:0];
                    2'd2:    store_word_o[15:8]  = wdata_i[7:0];
                    2'd3:    store_word_o[7:0]   = wdata_i[7:0];
                    default: store_word_o        = mem_word_i;
                endcase
            end
            SZ_HALF: begin
                load_word_o = {{16{sign_ext_i & lane16_s[15]}}, lane16_s};
                if (offset_i[1]) begin
                    store_word_o[15:0] = wdata_i[15:0];
                end else begin
                    store_word_o[31:16] = wdata_i[15:0];
                end
            end
            SZ_WORD: begin
                load_word_o  = mem_word_i;
                store_word_o = wdata_i;
            end
            default: begin
                load_word_o  = 32'h0000_0000;
                store_word_o = mem_word_i;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory with a fixed-latency IDLE/BUSY/DONE handshake,
// big-endian byte/half/word access and alignment error reporting.
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = LATENCY_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Stall,
    output logic        AddrErr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2 + 2;
    localparam logic [2:0] BUSY_LAST = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    logic [31:0]   mem_q [0:DEPTH-1];

    state_e        state_q;
    logic [2:0]    cnt_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          sext_q, sext_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic          ready_q;
    logic          aerr_q;
    logic [31:0]   rdata_q;

    logic          req_s;
    logic          capture_s;
    logic          enter_done_s;
    logic [31:0]   store_word_s;
    logic [31:0]   load_word_s;
    logic          unused_addr_s;

    // Address bits above the array size wrap away by design.
    assign unused_addr_s = ^Address[31:AW];

    assign req_s     = MemRead | MemWrite;
    assign capture_s = (state_q == ST_IDLE) && req_s;
    assign Stall     = capture_s || (state_q == ST_BUSY);
    assign Ready     = ready_q;
    assign AddrErr   = aerr_q;
    assign ReadData  = rdata_q;

    // Next-state view of the captured request so LATENCY=1 can finish in one step.
    always_comb begin
        if (capture_s) begin
            addr_d  = Address[AW-1:0];
            wdata_d = WriteData;
            size_d  = Size;
            sext_d  = SignExt;
            rd_d    = MemRead;
            wr_d    = MemWrite;
            err_d   = access_error(Size, Address[1:0], MemRead, MemWrite);
        end else begin
            addr_d  = addr_q;
            wdata_d = wdata_q;
            size_d  = size_q;
            sext_d  = sext_q;
            rd_d    = rd_q;
            wr_d    = wr_q;
            err_d   = err_q;
        end
    end

    // Cycle on which the access finishes and Ready/ReadData get loaded.
    always_comb begin
        if (capture_s && (LATENCY == 1)) begin
            enter_done_s = 1'b1;
        end else if ((state_q == ST_BUSY) && (cnt_q == BUSY_LAST)) begin
            enter_done_s = 1'b1;
        end else begin
            enter_done_s = 1'b0;
        end
    end

    data_mem_align u_align (
        .mem_word_i   (mem_q[addr_d[AW-1:2]]),
        .wdata_i      (wdata_d),
        .offset_i     (addr_d[1:0]),
        .size_i       (size_d),
        .sign_ext_i   (sext_d),
        .store_word_o (store_word_s),
        .load_word_o  (load_word_s)
    );

    // Handshake FSM with capture registers and registered outputs.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            ready_q <= 1'b0;
            aerr_q  <= 1'b0;
            rdata_q <= 32'h0000_0000;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            ready_q <= enter_done_s;
            aerr_q  <= enter_done_s & err_d;
            if (enter_done_s) begin
                if (err_d) begin
                    rdata_q <= 32'h0000_0000;
                end else if (rd_d) begin
                    rdata_q <= load_word_s;
                end else begin
                    rdata_q <= rdata_q;
                end
            end else begin
                rdata_q <= rdata_q;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 3'd0;
                    if (capture_s) begin
                        state_q <= enter_done_s ? ST_DONE : ST_BUSY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (enter_done_s) begin
                        state_q <= ST_DONE;
                        cnt_q   <= 3'd0;
                    end else begin
                        state_q <= ST_BUSY;
                        cnt_q   <= cnt_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 3'd0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    // Store commits on the edge leaving DONE, so a reset in DONE drops it.
    always_ff @(posedge CLK) begin
        if (Reset_L && (state_q == ST_DONE) && wr_q && !err_q) begin
            mem_q[addr_q[AW-1:2]] <= store_word_s;
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: handshake timing, lane steering,
// extension, error reporting, address wrap and reset abort.
module tb_data_mem_unit;
    import data_mem_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        SignExt;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Stall;
    logic        AddrErr;

    int checks = 0;
    int errors = 0;

    data_mem_unit dut (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Size      (Size),
        .SignExt   (SignExt),
        .ReadData  (ReadData),
        .Ready     (Ready),
        .Stall     (Stall),
        .AddrErr   (AddrErr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access from an IDLE negedge; leaves the bench at the negedge after DONE.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] sz, input logic sext,
                          input logic exp_err, input logic [31:0] exp_data);
        Address   = addr;
        WriteData = wdata;
        MemRead   = rd;
        MemWrite  = wr;
        Size      = sz;
        SignExt   = sext;
        #1;
        check({tag, ".stall_req"}, {31'd0, Stall}, 32'd1);
        check({tag, ".ready_req"}, {31'd0, Ready}, 32'd0);
        @(negedge CLK);
        check({tag, ".stall_busy"}, {31'd0, Stall}, 32'd1);
        check({tag, ".ready_busy"}, {31'd0, Ready}, 32'd0);
        @(negedge CLK);
        check({tag, ".ready_done"}, {31'd0, Ready}, 32'd1);
        check({tag, ".stall_done"}, {31'd0, Stall}, 32'd0);
        check({tag, ".adderr_done"}, {31'd0, AddrErr}, {31'd0, exp_err});
        if (rd || exp_err) begin
            check({tag, ".rdata"}, ReadData, exp_data);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge CLK);
        check({tag, ".ready_idle"}, {31'd0, Ready}, 32'd0);
        check({tag, ".adderr_idle"}, {31'd0, AddrErr}, 32'd0);
    endtask

    initial begin
        Reset_L   = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Size      = SZ_WORD;
        SignExt   = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst.ready", {31'd0, Ready}, 32'd0);
        check("rst.adderr", {31'd0, AddrErr}, 32'd0);
        check("rst.stall", {31'd0, Stall}, 32'd0);
        check("rst.rdata", ReadData, 32'h0);
        Reset_L = 1'b1;
        @(negedge CLK);

        // Word round trip
        access("w_st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, 1'b0, 32'h0);
        access("w_ld10", 1'b1, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'hDEADBEEF);

        // Byte store and loads
        access("w_st20", 1'b0, 1'b1, 32'h20, 32'h12345678, SZ_WORD, 1'b0, 1'b0, 32'h0);
        access("b_st21", 1'b0, 1'b1, 32'h21, 32'h0000009A, SZ_BYTE, 1'b0, 1'b0, 32'h0);
        access("w_ld20", 1'b1, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'h129A5678);
        access("b_ld21s", 1'b1, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b1, 1'b0, 32'hFFFFFF9A);
        access("b_ld21z", 1'b1, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b0, 1'b0, 32'h0000009A);
        access("h_st22", 1'b0, 1'b1, 32'h22, 32'h0000BEEF, SZ_HALF, 1'b0, 1'b0, 32'h0);
        access("w_ld20b", 1'b1, 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'h129ABEEF);
        access("b_ld23z", 1'b1, 1'b0, 32'h23, 32'h0, SZ_BYTE, 1'b0, 1'b0, 32'h000000EF);
        access("b_ld20s", 1'b1, 1'b0, 32'h20, 32'h0, SZ_BYTE, 1'b1, 1'b0, 32'h00000012);

        // Half loads
        access("w_st30", 1'b0, 1'b1, 32'h30, 32'h8001FFFF, SZ_WORD, 1'b0, 1'b0, 32'h0);
        access("h_ld30s", 1'b1, 1'b0, 32'h30, 32'h0, SZ_HALF, 1'b1, 1'b0, 32'hFFFF8001);
        access("h_ld32z", 1'b1, 1'b0, 32'h32, 32'h0, SZ_HALF, 1'b0, 1'b0, 32'h0000FFFF);

        // Error cases
        access("w_st40", 1'b0, 1'b1, 32'h40, 32'h0BADF00D, SZ_WORD, 1'b0, 1'b0, 32'h0);
        access("e_w31", 1'b0, 1'b1, 32'h31, 32'h55555555, SZ_WORD, 1'b0, 1'b1, 32'h0);
        access("e_rdwr", 1'b1, 1'b1, 32'h40, 32'h66666666, SZ_WORD, 1'b0, 1'b1, 32'h0);
        access("e_h33", 1'b1, 1'b0, 32'h33, 32'h0, SZ_HALF, 1'b0, 1'b1, 32'h0);
        access("e_sz11", 1'b0, 1'b1, 32'h30, 32'h77777777, SZ_ILL, 1'b0, 1'b1, 32'h0);
        access("w_ld30", 1'b1, 1'b0, 32'h30, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'h8001FFFF);
        access("w_ld40", 1'b1, 1'b0, 32'h40, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'h0BADF00D);

        // Address wrap
        access("w_st400", 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, SZ_WORD, 1'b0, 1'b0, 32'h0);
        access("w_ld000", 1'b1, 1'b0, 32'h000, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'hA5A5A5A5);

        // Reset abort during BUSY
        access("w_st50", 1'b0, 1'b1, 32'h50, 32'h11223344, SZ_WORD, 1'b0, 1'b0, 32'h0);
        Address   = 32'h50;
        WriteData = 32'hCAFEF00D;
        Size      = SZ_WORD;
        MemWrite  = 1'b1;
        @(negedge CLK);
        check("abort.stall_busy", {31'd0, Stall}, 32'd1);
        Reset_L  = 1'b0;
        MemWrite = 1'b0;
        @(negedge CLK);
        check("abort.ready0", {31'd0, Ready}, 32'd0);
        check("abort.stall0", {31'd0, Stall}, 32'd0);
        check("abort.rdata0", ReadData, 32'h0);
        @(negedge CLK);
        check("abort.ready1", {31'd0, Ready}, 32'd0);
        Reset_L = 1'b1;
        @(negedge CLK);
        check("abort.ready2", {31'd0, Ready}, 32'd0);
        access("w_ld50", 1'b1, 1'b0, 32'h50, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'h11223344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 The parameters SHALL be:
- DEPTH_LOG2, default 8, word-address width (256 x 32-bit words).
- LATENCY, default 2, cycles from request acceptance to Ready; legal range 1..7.

REQ-002 The ports SHALL be, in order:
- CLK  in  1  rising-edge clock.
- Reset_L  in  1  synchronous active-low reset.
- Address  in  32  byte address, driven from the ALU result bus BusW.
- WriteData  in  32  store data, right-justified.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- Size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- SignExt  in  1  sign-extend loads when 1, zero-extend when 0.
- ReadData  out  32  load result.
- Ready  out  1  one-cycle completion pulse.
- Stall  out  1  upstream hold request.
- AddrErr  out  1  one-cycle error pulse.

REQ-003 There SHALL be one clock; reset SHALL be synchronous and active-low on Reset_L.

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY and DONE.

REQ-005 In IDLE, a request (MemRead|MemWrite) SHALL be captured (Address, WriteData, Size, SignExt, op) and SHALL move the FSM to BUSY, or directly to DONE when LATENCY=1.

REQ-006 BUSY SHALL count LATENCY-1 cycles with a 3-bit counter and then enter DONE; a request captured at cycle t SHALL produce Ready=1 at t+LATENCY.

REQ-007 DONE SHALL last exactly one cycle, SHALL assert Ready, and SHALL return to IDLE; request inputs are ignored in DONE.

REQ-008 Stall SHALL be (IDLE & (MemRead|MemWrite)) | BUSY, and SHALL be 0 in DONE. Upstream holds its inputs stable while Stall=1.

REQ-009 Byte order SHALL be big-endian: byte offset 0 maps to bits 31:24, and half offset 0 maps to bits 31:16.

REQ-010 A store SHALL update only the addressed byte lanes, with the write committed at the DONE clock edge.

REQ-011 A load SHALL select the addressed lane and extend it to 32 bits per SignExt. ReadData SHALL be valid in DONE and held until the next DONE.

REQ-012 The word index SHALL be Address[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the memory size.

REQ-013 Each of the following SHALL be an error:
- half access with Address[0]=1;
- word access with Address[1:0]!=0;
- Size=11;
- MemRead and MemWrite asserted together.

REQ-014 On an error, the request SHALL still follow the normal latency, and in DONE:
- AddrErr=1 together with Ready=1;
- no memory write;
- ReadData=0.

REQ-015 A store followed immediately by a load to the same word SHALL return the stored data (the write is committed before the next IDLE capture).

Reset
REQ-016 Reset_L=0 at a clock edge SHALL force:
- state IDLE and counter 0;
- Ready=0, AddrErr=0;
- ReadData=32'h0.

REQ-017 Reset asserted while in BUSY or DONE SHALL abort the access with no memory write committed.

REQ-018 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-019 A shared package SHALL hold the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state encodings and the LATENCY default.

REQ-020 Lane selection, store merge and load extension SHALL live in one combinational sub-module, data_mem_align. The FSM, storage array and capture registers SHALL stay in data_mem_unit.

Verification
REQ-021 Word round trip:
- Stimulus: store 32'hDEADBEEF at 0x10, Size=10, then load 0x10.
- Response: Ready 2 cycles after each request; ReadData=32'hDEADBEEF; Stall high for 2 cycles per access.

REQ-022 Byte store and loads:
- Stimulus: word 0x12345678 at 0x20; store byte 8'h9A at 0x21; load word 0x20; then load byte 0x21 with SignExt=1 and with SignExt=0.
- Response: 32'h129A5678, then 32'hFFFFFF9A, then 32'h0000009A.

REQ-023 Half loads:
- Stimulus: word 0x8001FFFF at 0x30; load half 0x30 with SignExt=1, and load half 0x32 with SignExt=0.
- Response: 32'hFFFF8001 and 32'h0000FFFF.

REQ-024 Error cases:
- Stimulus: word store at 0x31; then MemRead=MemWrite=1 at 0x40.
- Response: each gives AddrErr=Ready=1 at the same cycle and ReadData=0; a later load of 0x30 and of 0x40 shows both words unchanged.

REQ-025 Wrap and reset abort:
- Wrap: store 32'hA5A5A5A5 at 0x400, then load 0x000; response is 32'hA5A5A5A5.
- Reset abort: store to 0x50 with Reset_L=0 pulsed in BUSY; response is Ready never pulses, and a later load of 0x50 returns the old value.
